// File: rtl/dp_seq_pkg.sv
// dp_seq_pkg: shared definitions for the datapath sequencer.
//   state_t     - sequencer FSM states
//   DEF_CNT_W   - default width of the length / issue counter
//   DEF_LAT     - default datapath latency in cycles (legal 1..32)
package dp_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int DEF_CNT_W = 16;
    localparam int DEF_LAT   = 4;

endpackage

// File: rtl/dp_seq_vpipe.sv
// dp_seq_vpipe: LAT-deep valid shift register that follows samples through
// the fixed-latency datapath.
//   clk      - clock
//   clr      - synchronous clear (reset or abort), wins over the shift
//   issue    - sample issued this cycle, enters bit 0
//   valid    - bit LAT-1, the datapath result is valid this cycle
//   drained  - all-zero flag for the register as it will be after this
//              cycle's shift, assuming no new issue
module dp_seq_vpipe #(
    parameter int LAT = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic issue,
    output logic valid,
    output logic drained
);

    logic [LAT-1:0] pipe;
    logic [LAT-1:0] shifted;

    // Shift form avoids a negative slice index when LAT is 1.
    assign shifted = pipe << 1;

    always_ff @(posedge clk) begin
        if (clr) begin
            pipe <= '0;
        end else begin
            pipe <= shifted | LAT'(issue);
        end
    end

    assign valid = pipe[LAT-1];

    // The top bit leaves on the next shift, so only the lower bits matter.
    assign drained = (shifted == '0);

endmodule

// File: rtl/dp_seq.sv
// dp_seq: sequencer for a generated datapath operator graph.
// Pulses init, issues len samples (honouring stall), tracks them through
// the datapath latency and pulses done once the pipeline has drained.
//   dp_seq_clk         - clock
//   dp_seq_reset       - synchronous active-high reset
//   dp_seq_start       - start command, sampled only in IDLE
//   dp_seq_len         - number of samples, captured with start
//   dp_seq_stall       - downstream backpressure, blocks issue this cycle
//   dp_seq_abort       - cancel current run (ignored in IDLE)
//   dp_seq_init        - one-cycle init pulse to all operators
//   dp_seq_in_disable  - low only on issue cycles
//   dp_seq_valid_out   - datapath output valid this cycle
//   dp_seq_busy        - high whenever not IDLE
//   dp_seq_done        - one-cycle completion pulse
//   dp_seq_issue_cnt   - samples issued in current or last run
//   dp_seq_state       - current FSM state, for observation
//
// Handshake: a sample is issued in a cycle exactly when the FSM is in RUN,
// stall is low and abort is low; in_disable is the inverse of that issue
// flag. in_disable is built from the registered state gated by the same
// cycle's stall/abort, so a stall or abort suppresses the issue of the very
// cycle in which it is seen. All other outputs are flops.
module dp_seq
    import dp_seq_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int LAT   = DEF_LAT
) (
    input  logic             dp_seq_clk,
    input  logic             dp_seq_reset,
    input  logic             dp_seq_start,
    input  logic [CNT_W-1:0] dp_seq_len,
    input  logic             dp_seq_stall,
    input  logic             dp_seq_abort,
    output logic             dp_seq_init,
    output logic             dp_seq_in_disable,
    output logic             dp_seq_valid_out,
    output logic             dp_seq_busy,
    output logic             dp_seq_done,
    output logic [CNT_W-1:0] dp_seq_issue_cnt,
    output state_t           dp_seq_state
);

    state_t           state;
    logic [CNT_W-1:0] len_q;
    logic             issue;
    logic             abort_act;
    logic             drained;

    assign abort_act = dp_seq_abort && (state != ST_IDLE);
    assign issue     = (state == ST_RUN) && !dp_seq_stall && !dp_seq_abort;

    assign dp_seq_in_disable = !issue;
    assign dp_seq_state      = state;

    dp_seq_vpipe #(
        .LAT(LAT)
    ) u_vpipe (
        .clk     (dp_seq_clk),
        .clr     (dp_seq_reset || abort_act),
        .issue   (issue),
        .valid   (dp_seq_valid_out),
        .drained (drained)
    );

    always_ff @(posedge dp_seq_clk) begin
        if (dp_seq_reset) begin
            state            <= ST_IDLE;
            len_q            <= '0;
            dp_seq_issue_cnt <= '0;
            dp_seq_init      <= 1'b0;
            dp_seq_busy      <= 1'b0;
            dp_seq_done      <= 1'b0;
        end else begin
            dp_seq_init <= 1'b0;
            dp_seq_done <= 1'b0;
            if (abort_act) begin
                // issue_cnt is deliberately left frozen.
                state       <= ST_IDLE;
                dp_seq_busy <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (dp_seq_start) begin
                            len_q            <= dp_seq_len;
                            dp_seq_issue_cnt <= '0;
                            dp_seq_busy      <= 1'b1;
                            if (dp_seq_len == '0) begin
                                state       <= ST_DONE;
                                dp_seq_done <= 1'b1;
                            end else begin
                                state       <= ST_INIT;
                                dp_seq_init <= 1'b1;
                            end
                        end
                    end
                    ST_INIT: begin
                        state <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (!dp_seq_stall) begin
                            dp_seq_issue_cnt <= dp_seq_issue_cnt + CNT_W'(1);
                            if (dp_seq_issue_cnt == len_q - CNT_W'(1)) begin
                                state <= ST_DRAIN;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (drained) begin
                            state       <= ST_DONE;
                            dp_seq_done <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        state       <= ST_IDLE;
                        dp_seq_busy <= 1'b0;
                    end
                    default: begin
                        state       <= ST_IDLE;
                        dp_seq_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dp_seq.sv
// tb_dp_seq: directed bench for dp_seq (LAT=4, CNT_W=16).
// Cycle c begins 1 time unit after a rising edge: inputs for cycle c are
// driven then, outputs are sampled 3 units later, well before the next edge.
module tb_dp_seq;
    import dp_seq_pkg::*;

    localparam int CNT_W = 16;
    localparam int LAT   = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             stall;
    logic             abort;
    logic             init;
    logic             in_disable;
    logic             valid_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] issue_cnt;
    state_t           st;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dp_seq #(
        .CNT_W(CNT_W),
        .LAT  (LAT)
    ) dut (
        .dp_seq_clk        (clk),
        .dp_seq_reset      (reset),
        .dp_seq_start      (start),
        .dp_seq_len        (len),
        .dp_seq_stall      (stall),
        .dp_seq_abort      (abort),
        .dp_seq_init       (init),
        .dp_seq_in_disable (in_disable),
        .dp_seq_valid_out  (valid_out),
        .dp_seq_busy       (busy),
        .dp_seq_done       (done),
        .dp_seq_issue_cnt  (issue_cnt),
        .dp_seq_state      (st)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; len = '0; stall = 1'b0; abort = 1'b0;
        next_cycle();
        next_cycle();
        #3;
        total++; if (init !== 1'b0)       begin bad++; $display("FAIL reset init got=%b exp=0", init); end
        total++; if (in_disable !== 1'b1) begin bad++; $display("FAIL reset in_disable got=%b exp=1", in_disable); end
        total++; if (valid_out !== 1'b0)  begin bad++; $display("FAIL reset valid_out got=%b exp=0", valid_out); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0)       begin bad++; $display("FAIL reset done got=%b exp=0", done); end
        total++; if (issue_cnt !== 16'd0) begin bad++; $display("FAIL reset issue_cnt got=%0d exp=0", issue_cnt); end
        total++; if (st !== ST_IDLE)      begin bad++; $display("FAIL reset state got=%0d exp=%0d", st, ST_IDLE); end
        reset = 1'b0;
        next_cycle();
    endtask

    // len=3, no stall: init c1, issues c2-4, valid c6-8, done c9.
    task automatic test_basic(input string tag);
        logic e_init, e_dis, e_val, e_done, e_busy;
        for (int c = 0; c <= 11; c++) begin
            start = (c == 0); len = 16'd3;
            #3;
            e_init = (c == 1);
            e_dis  = !(c >= 2 && c <= 4);
            e_val  = (c >= 6 && c <= 8);
            e_done = (c == 9);
            e_busy = (c >= 1 && c <= 9);
            total++; if (init !== e_init)      begin bad++; $display("FAIL %s init c=%0d got=%b exp=%b", tag, c, init, e_init); end
            total++; if (in_disable !== e_dis) begin bad++; $display("FAIL %s in_disable c=%0d got=%b exp=%b", tag, c, in_disable, e_dis); end
            total++; if (valid_out !== e_val)  begin bad++; $display("FAIL %s valid_out c=%0d got=%b exp=%b", tag, c, valid_out, e_val); end
            total++; if (done !== e_done)      begin bad++; $display("FAIL %s done c=%0d got=%b exp=%b", tag, c, done, e_done); end
            total++; if (busy !== e_busy)      begin bad++; $display("FAIL %s busy c=%0d got=%b exp=%b", tag, c, busy, e_busy); end
            next_cycle();
        end
        start = 1'b0;
        #3;
        total++; if (issue_cnt !== 16'd3) begin bad++; $display("FAIL %s issue_cnt got=%0d exp=3", tag, issue_cnt); end
        next_cycle();
    endtask

    // len=4, stall c3-4: issues c2,5,6,7; valid c6,9,10,11; done c12.
    task automatic test_stall();
        logic e_dis, e_val, e_done;
        for (int c = 0; c <= 14; c++) begin
            start = (c == 0); len = 16'd4; stall = (c == 3 || c == 4);
            #3;
            e_dis  = !(c == 2 || c == 5 || c == 6 || c == 7);
            e_val  = (c == 6 || c == 9 || c == 10 || c == 11);
            e_done = (c == 12);
            total++; if (in_disable !== e_dis) begin bad++; $display("FAIL stall in_disable c=%0d got=%b exp=%b", c, in_disable, e_dis); end
            total++; if (valid_out !== e_val)  begin bad++; $display("FAIL stall valid_out c=%0d got=%b exp=%b", c, valid_out, e_val); end
            total++; if (done !== e_done)      begin bad++; $display("FAIL stall done c=%0d got=%b exp=%b", c, done, e_done); end
            next_cycle();
        end
        start = 1'b0; stall = 1'b0;
        #3;
        total++; if (issue_cnt !== 16'd4) begin bad++; $display("FAIL stall issue_cnt got=%0d exp=4", issue_cnt); end
        next_cycle();
    endtask

    // len=0 at c0 (done c1), then len=2 at c2: init c3, issues c4-5,
    // valid c8-9, done c10.
    task automatic test_len_zero();
        logic e_init, e_dis, e_val, e_done, e_busy;
        for (int c = 0; c <= 12; c++) begin
            start = (c == 0 || c == 2); len = (c == 0) ? 16'd0 : 16'd2;
            #3;
            e_init = (c == 3);
            e_dis  = !(c == 4 || c == 5);
            e_val  = (c == 8 || c == 9);
            e_done = (c == 1 || c == 10);
            e_busy = (c == 1) || (c >= 3 && c <= 10);
            total++; if (init !== e_init)      begin bad++; $display("FAIL len0 init c=%0d got=%b exp=%b", c, init, e_init); end
            total++; if (in_disable !== e_dis) begin bad++; $display("FAIL len0 in_disable c=%0d got=%b exp=%b", c, in_disable, e_dis); end
            total++; if (valid_out !== e_val)  begin bad++; $display("FAIL len0 valid_out c=%0d got=%b exp=%b", c, valid_out, e_val); end
            total++; if (done !== e_done)      begin bad++; $display("FAIL len0 done c=%0d got=%b exp=%b", c, done, e_done); end
            total++; if (busy !== e_busy)      begin bad++; $display("FAIL len0 busy c=%0d got=%b exp=%b", c, busy, e_busy); end
            next_cycle();
        end
        start = 1'b0;
        #3;
        total++; if (issue_cnt !== 16'd2) begin bad++; $display("FAIL len0 issue_cnt got=%0d exp=2", issue_cnt); end
        next_cycle();
    endtask

    // len=10, abort at c5 (with stall low): issues c2-4 only, IDLE at c6.
    task automatic test_abort();
        logic e_dis, e_busy;
        for (int c = 0; c <= 12; c++) begin
            start = (c == 0); len = 16'd10; abort = (c == 5);
            #3;
            e_dis  = !(c >= 2 && c <= 4);
            e_busy = (c >= 1 && c <= 5);
            total++; if (in_disable !== e_dis) begin bad++; $display("FAIL abort in_disable c=%0d got=%b exp=%b", c, in_disable, e_dis); end
            total++; if (valid_out !== 1'b0)   begin bad++; $display("FAIL abort valid_out c=%0d got=%b exp=0", c, valid_out); end
            total++; if (done !== 1'b0)        begin bad++; $display("FAIL abort done c=%0d got=%b exp=0", c, done); end
            total++; if (busy !== e_busy)      begin bad++; $display("FAIL abort busy c=%0d got=%b exp=%b", c, busy, e_busy); end
            if (c == 6) begin
                total++; if (st !== ST_IDLE) begin bad++; $display("FAIL abort state c=6 got=%0d exp=%0d", st, ST_IDLE); end
            end
            next_cycle();
        end
        abort = 1'b0; start = 1'b0;
        #3;
        total++; if (issue_cnt !== 16'd3) begin bad++; $display("FAIL abort issue_cnt got=%0d exp=3", issue_cnt); end
        next_cycle();
    endtask

    // Second start at c4 during a len=3 run is ignored.
    task automatic test_start_while_busy();
        logic e_init, e_done;
        for (int c = 0; c <= 14; c++) begin
            start = (c == 0 || c == 4); len = (c == 0) ? 16'd3 : 16'd7;
            #3;
            e_init = (c == 1);
            e_done = (c == 9);
            total++; if (init !== e_init) begin bad++; $display("FAIL busy_start init c=%0d got=%b exp=%b", c, init, e_init); end
            total++; if (done !== e_done) begin bad++; $display("FAIL busy_start done c=%0d got=%b exp=%b", c, done, e_done); end
            next_cycle();
        end
        start = 1'b0;
        #3;
        total++; if (issue_cnt !== 16'd3) begin bad++; $display("FAIL busy_start issue_cnt got=%0d exp=3", issue_cnt); end
        next_cycle();
    endtask

    // Start and abort together in IDLE: start wins. len=1 -> init c1,
    // issue c2, valid c6, done c7.
    task automatic test_start_abort_idle();
        logic e_init, e_dis, e_val, e_done;
        for (int c = 0; c <= 9; c++) begin
            start = (c == 0); abort = (c == 0); len = 16'd1;
            #3;
            e_init = (c == 1);
            e_dis  = !(c == 2);
            e_val  = (c == 6);
            e_done = (c == 7);
            total++; if (init !== e_init)      begin bad++; $display("FAIL start_abort init c=%0d got=%b exp=%b", c, init, e_init); end
            total++; if (in_disable !== e_dis) begin bad++; $display("FAIL start_abort in_disable c=%0d got=%b exp=%b", c, in_disable, e_dis); end
            total++; if (valid_out !== e_val)  begin bad++; $display("FAIL start_abort valid_out c=%0d got=%b exp=%b", c, valid_out, e_val); end
            total++; if (done !== e_done)      begin bad++; $display("FAIL start_abort done c=%0d got=%b exp=%b", c, done, e_done); end
            next_cycle();
        end
        start = 1'b0; abort = 1'b0;
    endtask

    // len=3 run, reset asserted at c6 (DRAIN, valid high) -> reset values at c7.
    task automatic test_reset_in_drain();
        for (int c = 0; c <= 6; c++) begin
            start = (c == 0); len = 16'd3; reset = (c == 6);
            #3;
            if (c == 6) begin
                total++; if (st !== ST_DRAIN)    begin bad++; $display("FAIL rst_drain pre state got=%0d exp=%0d", st, ST_DRAIN); end
                total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL rst_drain pre valid_out got=%b exp=1", valid_out); end
            end
            next_cycle();
        end
        reset = 1'b0; start = 1'b0;
        #3;
        total++; if (init !== 1'b0)       begin bad++; $display("FAIL rst_drain init got=%b exp=0", init); end
        total++; if (in_disable !== 1'b1) begin bad++; $display("FAIL rst_drain in_disable got=%b exp=1", in_disable); end
        total++; if (valid_out !== 1'b0)  begin bad++; $display("FAIL rst_drain valid_out got=%b exp=0", valid_out); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rst_drain busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0)       begin bad++; $display("FAIL rst_drain done got=%b exp=0", done); end
        total++; if (issue_cnt !== 16'd0) begin bad++; $display("FAIL rst_drain issue_cnt got=%0d exp=0", issue_cnt); end
        total++; if (st !== ST_IDLE)      begin bad++; $display("FAIL rst_drain state got=%0d exp=%0d", st, ST_IDLE); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_basic("basic");
        test_stall();
        test_len_zero();
        test_abort();
        test_start_while_busy();
        test_start_abort_idle();
        test_reset_in_drain();
        test_basic("after_reset");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
